pixel_scan_ctrl: RTL and testbench

//  Raster-scan scheduler sitting between the pixel colour engine and the video output stream.

---
 rtl/video_pkg.sv | 16 +
 rtl/pixel_scan_ctrl_if.sv | 29 ++
 rtl/raster_counter.sv | 41 ++++
 rtl/pixel_scan_ctrl.sv | 114 +++++++++++
 tb/tb_pixel_scan_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared types and default geometry for the video scan path.
package video_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_RBG_SIZE      = 24;
  localparam int unsigned DEF_SCREEN_WIDTH  = 640;
  localparam int unsigned DEF_SCREEN_HEIGHT = 480;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT
  } scan_state_t;

endpackage

// File: rtl/pixel_scan_ctrl_if.sv
// Coordinate request, colour return and downstream pixel stream of the scan controller.
interface pixel_scan_ctrl_if #(
    parameter int unsigned DATA_WIDTH = video_pkg::DEF_DATA_WIDTH,
    parameter int unsigned RBG_SIZE   = video_pkg::DEF_RBG_SIZE
);

    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_x;
    logic [DATA_WIDTH-1:0] req_y;
    logic                  col_valid;
    logic [RBG_SIZE-1:0]   col_i;
    logic                  out_valid;
    logic                  out_ready;
    logic [RBG_SIZE-1:0]   out_colour;
    logic                  out_sof;
    logic                  out_eol;

    modport master (
        output req_valid, req_x, req_y, out_valid, out_colour, out_sof, out_eol,
        input  req_ready, col_valid, col_i, out_ready
    );

    modport slave (
        input  req_valid, req_x, req_y, out_valid, out_colour, out_sof, out_eol,
        output req_ready, col_valid, col_i, out_ready
    );

endinterface

// File: rtl/raster_counter.sv
// x/y raster position; advances one pixel per accepted output and wraps at end of frame.
module raster_counter #(
    parameter  int unsigned SCREEN_WIDTH  = video_pkg::DEF_SCREEN_WIDTH,
    parameter  int unsigned SCREEN_HEIGHT = video_pkg::DEF_SCREEN_HEIGHT,
    localparam int unsigned XW            = $clog2(SCREEN_WIDTH),
    localparam int unsigned YW            = $clog2(SCREEN_HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          sof,
    output logic          eol,
    output logic          last_pixel
);

    localparam logic [XW-1:0] XMAX = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(SCREEN_HEIGHT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (eol) begin
                x <= '0;
                y <= (y == YMAX) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_comb begin
        eol        = (x == XMAX);
        sof        = (x == '0) && (y == '0);
        last_pixel = eol && (y == YMAX);
    end

endmodule

// File: rtl/pixel_scan_ctrl.sv
// Raster-scan scheduler: requests a colour per pixel, then streams it out with sof/eol markers.
module pixel_scan_ctrl
    import video_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned RBG_SIZE      = DEF_RBG_SIZE,
    parameter int unsigned SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT = DEF_SCREEN_HEIGHT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  stop,
    pixel_scan_ctrl_if.master     bus,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] frame_count
);

    localparam int unsigned XW = $clog2(SCREEN_WIDTH);
    localparam int unsigned YW = $clog2(SCREEN_HEIGHT);

    scan_state_t   state;
    logic          stop_seen;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
    logic          last_pixel;
    logic          advance;

    assign advance   = (state == EMIT) && bus.out_valid && bus.out_ready;
    assign bus.req_x = DATA_WIDTH'(x);
    assign bus.req_y = DATA_WIDTH'(y);

    raster_counter #(
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .SCREEN_HEIGHT(SCREEN_HEIGHT)
    ) u_raster (
        .clk       (clk),
        .reset     (reset),
        .advance   (advance),
        .x         (x),
        .y         (y),
        .sof       (sof),
        .eol       (eol),
        .last_pixel(last_pixel)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            stop_seen      <= 1'b0;
            busy           <= 1'b0;
            frame_count    <= '0;
            bus.req_valid  <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_colour <= '0;
            bus.out_sof    <= 1'b0;
            bus.out_eol    <= 1'b0;
        end else begin
            if (state != IDLE && stop) stop_seen <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        // A stop arriving with start limits the run to this one frame.
                        stop_seen     <= stop;
                        busy          <= 1'b1;
                        bus.req_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.req_ready) begin
                        bus.req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.col_valid) begin
                        bus.out_colour <= bus.col_i;
                        bus.out_sof    <= sof;
                        bus.out_eol    <= eol;
                        bus.out_valid  <= 1'b1;
                        state          <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_sof   <= 1'b0;
                        bus.out_eol   <= 1'b0;
                        if (last_pixel) begin
                            frame_count <= frame_count + 1'b1;
                            if (continuous && !stop_seen && !stop) begin
                                bus.req_valid <= 1'b1;
                                state         <= ISSUE;
                            end else begin
                                stop_seen <= 1'b0;
                                busy      <= 1'b0;
                                state     <= IDLE;
                            end
                        end else begin
                            bus.req_valid <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Directed bench for pixel_scan_ctrl on a 4x3 screen with a hand-driven colour engine.
module tb_pixel_scan_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 24;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          stop = 1'b0;
    logic          busy;
    logic [DW-1:0] frame_count;

    int n_vec = 0;
    int n_err = 0;

    pixel_scan_ctrl_if #(.DATA_WIDTH(DW), .RBG_SIZE(CW)) bus ();

    pixel_scan_ctrl #(
        .DATA_WIDTH   (DW),
        .RBG_SIZE     (CW),
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
        .stop       (stop),
        .bus        (bus),
        .busy       (busy),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req_valid"}, 32'(bus.req_valid), 0);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, ".out_sof"}, 32'(bus.out_sof), 0);
        chk({tag, ".out_eol"}, 32'(bus.out_eol), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".out_colour"}, 32'(bus.out_colour), 0);
        chk({tag, ".frame_count"}, frame_count, 0);
        chk({tag, ".req_x"}, bus.req_x, 0);
        chk({tag, ".req_y"}, bus.req_y, 0);
    endtask

    // Expects the DUT in ISSUE for pixel (x,y); leaves it after the output accept.
    task automatic run_pixel(input int x, input int y, input int req_hold, input int out_hold,
                             input bit noise, input bit pulse_stop, input logic [CW-1:0] colour);
        chk("req_valid", 32'(bus.req_valid), 1);
        chk("req_x", bus.req_x, 32'(x));
        chk("req_y", bus.req_y, 32'(y));
        for (int i = 0; i < req_hold; i++) begin
            if (noise && i == 0) begin
                bus.col_valid = 1'b1;
                bus.col_i     = 24'h123456;
                start         = 1'b1;
            end
            tick();
            bus.col_valid = 1'b0;
            start         = 1'b0;
            chk("hold.req_valid", 32'(bus.req_valid), 1);
            chk("hold.req_x", bus.req_x, 32'(x));
            chk("hold.req_y", bus.req_y, 32'(y));
            chk("hold.out_valid", 32'(bus.out_valid), 0);
        end
        bus.req_ready = 1'b1;
        stop          = pulse_stop;
        tick();
        bus.req_ready = 1'b0;
        stop          = 1'b0;
        chk("wait.req_valid", 32'(bus.req_valid), 0);
        bus.col_valid = 1'b1;
        bus.col_i     = colour;
        tick();
        bus.col_valid = 1'b0;
        bus.col_i     = '0;
        chk("out_valid", 32'(bus.out_valid), 1);
        chk("out_colour", 32'(bus.out_colour), 32'(colour));
        chk("out_sof", 32'(bus.out_sof), 32'(x == 0 && y == 0));
        chk("out_eol", 32'(bus.out_eol), 32'(x == W - 1));
        for (int i = 0; i < out_hold; i++) begin
            tick();
            chk("stall.out_valid", 32'(bus.out_valid), 1);
            chk("stall.out_colour", 32'(bus.out_colour), 32'(colour));
            chk("stall.req_valid", 32'(bus.req_valid), 0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic run_frame(input int fc_exp, input bit more, input int stop_idx,
                             input bit stalls);
        for (int yy = 0; yy < int'(H); yy++) begin
            for (int xx = 0; xx < int'(W); xx++) begin
                int          idx;
                logic [CW-1:0] c;
                idx = yy * int'(W) + xx;
                c   = {8'(8'h10 + yy), 8'(8'h20 + xx), 8'h5A};
                if (stalls && idx == 3)
                    run_pixel(xx, yy, 0, 4, 1'b0, 1'b0, 24'hABCDEF);
                else if (stalls && idx == 6)
                    run_pixel(xx, yy, 5, 0, 1'b1, 1'b0, c);
                else
                    run_pixel(xx, yy, 0, 0, 1'b0, idx == stop_idx, c);
            end
        end
        chk("frame_count", frame_count, 32'(fc_exp));
        chk("end.busy", 32'(busy), 32'(more));
        chk("end.req_valid", 32'(bus.req_valid), 32'(more));
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1 chk_all_zero("reset");
        #2 reset = 1'b1;
        tick();
    endtask

    initial begin
        bus.req_ready = 1'b0;
        bus.col_valid = 1'b0;
        bus.col_i     = '0;
        bus.out_ready = 1'b0;
        #3;
        chk_all_zero("por");
        #4 reset = 1'b1;
        tick();

        // stray colour and stop while idle do nothing
        bus.col_valid = 1'b1;
        bus.col_i     = 24'h777777;
        stop          = 1'b1;
        tick();
        bus.col_valid = 1'b0;
        stop          = 1'b0;
        chk("idle.out_valid", 32'(bus.out_valid), 0);
        chk("idle.busy", 32'(busy), 0);

        // single frame with request and output stalls
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start.busy", 32'(busy), 1);
        run_frame(1, 1'b0, -1, 1'b1);
        tick();
        chk("after.req_valid", 32'(bus.req_valid), 0);
        chk("after.busy", 32'(busy), 0);

        // reset mid-frame at (1,2)
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++)
            run_pixel(i % int'(W), i / int'(W), 0, 0, 1'b0, 1'b0, 24'(i));
        chk("mid.req_x", bus.req_x, 1);
        chk("mid.req_y", bus.req_y, 2);
        do_reset();
        bus.col_valid = 1'b1;
        bus.col_i     = 24'h999999;
        tick();
        bus.col_valid = 1'b0;
        chk("postrst.out_valid", 32'(bus.out_valid), 0);
        chk("postrst.req_valid", 32'(bus.req_valid), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame(1, 1'b0, -1, 1'b0);

        // continuous with stop during frame 2
        do_reset();
        continuous = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        run_frame(1, 1'b1, -1, 1'b0);
        run_frame(2, 1'b0, 5, 1'b0);
        tick();
        tick();
        chk("stopped.busy", 32'(busy), 0);
        chk("stopped.frame_count", frame_count, 2);

        // start and stop together: one frame only even with continuous set
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        run_frame(3, 1'b0, -1, 1'b0);
        continuous = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
